// File: rtl/core_config_pkg.sv
`default_nettype none
// ============================================================================
// Package : core_config_pkg
// Purpose : Core-wide configuration shared by the memory arbiter: data width,
//           default requester count and the arbiter state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package core_config_pkg;

  localparam int XLEN             = 32;
  localparam int ARB_NREQ_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module  : rr_picker
// Purpose : Combinational circular first-set finder. Starting at ptr_i and
//           wrapping past NREQ-1, returns the first index whose req_i bit is
//           set.
// Ports   : req_i   [NREQ]         request vector
//           ptr_i   [clog2(NREQ)]  scan start position (must be < NREQ)
//           valid_o                at least one request bit is set
//           idx_o   [clog2(NREQ)]  chosen index (0 when valid_o is low)
// Revision: 1.0 - initial release
// ============================================================================
module rr_picker #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic                    valid_o,
  output logic [$clog2(NREQ)-1:0] idx_o
);

  localparam int IDW = $clog2(NREQ);

  // Scan from the farthest offset down to offset 0 so that the candidate
  // closest to the pointer is the last one written and therefore wins.
  always_comb begin
    int j;
    valid_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) begin
        j = j - NREQ;
      end
      if (req_i[j]) begin
        valid_o = 1'b1;
        idx_o   = IDW'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Purpose : Shares one RAM/peripheral slave port between NREQ requesters
//           (0 = core data port, others = DMA / debug). Round-robin grant,
//           one outstanding transaction, registered ack/response.
// Config  : ARB_TIMEOUT_EN - when defined, a BUSY-cycle counter aborts a
//           transaction after TIMEOUT cycles without s_ack (m_err = 1,
//           m_rdata = 0). When undefined, BUSY waits indefinitely.
// Ports   : clk, rst                    clock, synchronous active-high reset
//           m_req/m_we       [NREQ]     per-requester request / write enable
//           m_addr/m_wdata   [NREQ*XLEN] packed, requester i at [i*XLEN+:XLEN]
//           m_byteen         [NREQ*XLEN/8] packed byte enables
//           m_ack            [NREQ]     one-hot one-cycle completion pulse
//           m_rdata, m_err              response, valid with m_ack
//           s_req/s_we/s_addr/s_byteen/s_wdata  forwarded slave request
//           s_ack/s_rdata/s_err         slave completion
//           grant_id                    current or last granted requester
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter
  import core_config_pkg::*;
#(
  parameter int XLEN = core_config_pkg::XLEN,
  parameter int NREQ = ARB_NREQ_DEFAULT
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          m_req,
  input  logic [NREQ-1:0]          m_we,
  input  logic [NREQ*XLEN-1:0]     m_addr,
  input  logic [NREQ*(XLEN/8)-1:0] m_byteen,
  input  logic [NREQ*XLEN-1:0]     m_wdata,
  output logic [NREQ-1:0]          m_ack,
  output logic [XLEN-1:0]          m_rdata,
  output logic                     m_err,
  output logic                     s_req,
  output logic                     s_we,
  output logic [XLEN-1:0]          s_addr,
  output logic [XLEN/8-1:0]        s_byteen,
  output logic [XLEN-1:0]          s_wdata,
  input  logic                     s_ack,
  input  logic [XLEN-1:0]          s_rdata,
  input  logic                     s_err,
  output logic [$clog2(NREQ)-1:0]  grant_id
);

  localparam int IDW = $clog2(NREQ);
  localparam int BW  = XLEN / 8;

  arb_state_t        state_q, state_d;
  logic              s_req_q, s_req_d;
  logic              s_we_q, s_we_d;
  logic [XLEN-1:0]   s_addr_q, s_addr_d;
  logic [BW-1:0]     s_byteen_q, s_byteen_d;
  logic [XLEN-1:0]   s_wdata_q, s_wdata_d;
  logic [NREQ-1:0]   m_ack_q, m_ack_d;
  logic [XLEN-1:0]   m_rdata_q, m_rdata_d;
  logic              m_err_q, m_err_d;
  logic [IDW-1:0]    grant_q, grant_d;
  logic [IDW-1:0]    rr_q, rr_d;

  logic              pick_valid;
  logic [IDW-1:0]    pick_idx;
  logic              timeout_hit;
  logic              done;
  logic [IDW-1:0]    rr_next;

  rr_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req_i   (m_req),
    .ptr_i   (rr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Held at zero outside BUSY so it is already clear on BUSY entry;
  // saturates so it cannot wrap while waiting for the abort to take effect.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != BUSY) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(TIMEOUT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign timeout_hit = (state_q == BUSY) && (cnt_q == CW'(TIMEOUT));
`else
  assign timeout_hit = 1'b0;
`endif

  // s_ack has priority: a timeout coinciding with s_ack is a normal completion.
  assign done    = s_ack || timeout_hit;
  assign rr_next = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + IDW'(1);

  // State register (plus all registered outputs).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      s_req_q    <= 1'b0;
      s_we_q     <= 1'b0;
      s_addr_q   <= '0;
      s_byteen_q <= '0;
      s_wdata_q  <= '0;
      m_ack_q    <= '0;
      m_rdata_q  <= '0;
      m_err_q    <= 1'b0;
      grant_q    <= '0;
      rr_q       <= '0;
    end else begin
      state_q    <= state_d;
      s_req_q    <= s_req_d;
      s_we_q     <= s_we_d;
      s_addr_q   <= s_addr_d;
      s_byteen_q <= s_byteen_d;
      s_wdata_q  <= s_wdata_d;
      m_ack_q    <= m_ack_d;
      m_rdata_q  <= m_rdata_d;
      m_err_q    <= m_err_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
    end
  end

  // Next-state logic. RESP never grants, giving the acked requester a cycle
  // to drop m_req before the next arbitration.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = BUSY;
      BUSY:    if (done)       state_d = RESP;
      RESP:                    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    s_req_d    = s_req_q;
    s_we_d     = s_we_q;
    s_addr_d   = s_addr_q;
    s_byteen_d = s_byteen_q;
    s_wdata_d  = s_wdata_q;
    m_ack_d    = '0;
    m_rdata_d  = m_rdata_q;
    m_err_d    = m_err_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          s_req_d    = 1'b1;
          s_we_d     = m_we[pick_idx];
          s_addr_d   = m_addr[pick_idx*XLEN +: XLEN];
          s_byteen_d = m_byteen[pick_idx*BW +: BW];
          s_wdata_d  = m_wdata[pick_idx*XLEN +: XLEN];
          grant_d    = pick_idx;
        end
      end
      BUSY: begin
        if (done) begin
          s_req_d          = 1'b0;
          m_ack_d[grant_q] = 1'b1;
          rr_d             = rr_next;
          if (s_ack) begin
            m_rdata_d = s_rdata;
            m_err_d   = s_err;
          end else begin
            m_rdata_d = '0;
            m_err_d   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign s_req    = s_req_q;
  assign s_we     = s_we_q;
  assign s_addr   = s_addr_q;
  assign s_byteen = s_byteen_q;
  assign s_wdata  = s_wdata_q;
  assign m_ack    = m_ack_q;
  assign m_rdata  = m_rdata_q;
  assign m_err    = m_err_q;
  assign grant_id = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Purpose : Self-checking bench for mem_arbiter (NREQ = 3, XLEN = 32).
//           Timeout scenarios are compiled in with ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam int BW   = XLEN / 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       m_req;
  logic [NREQ-1:0]       m_we;
  logic [NREQ*XLEN-1:0]  m_addr;
  logic [NREQ*BW-1:0]    m_byteen;
  logic [NREQ*XLEN-1:0]  m_wdata;
  logic [NREQ-1:0]       m_ack;
  logic [XLEN-1:0]       m_rdata;
  logic                  m_err;
  logic                  s_req;
  logic                  s_we;
  logic [XLEN-1:0]       s_addr;
  logic [BW-1:0]         s_byteen;
  logic [XLEN-1:0]       s_wdata;
  logic                  s_ack;
  logic [XLEN-1:0]       s_rdata;
  logic                  s_err;
  logic [1:0]            grant_id;

  always #5 clk = ~clk;

  mem_arbiter #(
    .XLEN (XLEN),
    .NREQ (NREQ)
`ifdef ARB_TIMEOUT_EN
    ,
    .TIMEOUT (8)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_byteen (m_byteen),
    .m_wdata  (m_wdata),
    .m_ack    (m_ack),
    .m_rdata  (m_rdata),
    .m_err    (m_err),
    .s_req    (s_req),
    .s_we     (s_we),
    .s_addr   (s_addr),
    .s_byteen (s_byteen),
    .s_wdata  (s_wdata),
    .s_ack    (s_ack),
    .s_rdata  (s_rdata),
    .s_err    (s_err),
    .grant_id (grant_id)
  );

  // Requester-side view: each requester's pending transaction.
  logic [NREQ-1:0] req;
  logic            we_r   [NREQ];
  logic [XLEN-1:0] addr_r [NREQ];
  logic [BW-1:0]   be_r   [NREQ];
  logic [XLEN-1:0] wdata_r[NREQ];

  int              ptr;        // round-robin start position the spec implies
  logic [XLEN-1:0] exp_rdata;  // last response data delivered
  int              checks;
  int              errors;

  task automatic drive();
    m_req = req;
    for (int i = 0; i < NREQ; i++) begin
      m_we[i]                  = we_r[i];
      m_addr[i*XLEN +: XLEN]   = addr_r[i];
      m_byteen[i*BW +: BW]     = be_r[i];
      m_wdata[i*XLEN +: XLEN]  = wdata_r[i];
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic int pick(logic [NREQ-1:0] mask, int p);
    for (int k = 0; k < NREQ; k++) begin
      if (mask[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(int g);
    logic [NREQ-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; req = '0; s_ack = 1'b0; s_err = 1'b0; s_rdata = 32'hA5A5_A5A5;
    for (int i = 0; i < NREQ; i++) begin
      we_r[i] = 1'b0; addr_r[i] = '0; be_r[i] = '0; wdata_r[i] = '0;
    end
    drive();
    next_cycle(); next_cycle(); sample();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL reset_s_req: got %b want 0", s_req); end
    checks++; if (m_ack !== '0) begin errors++; $display("FAIL reset_m_ack: got %b want 000", m_ack); end
    checks++; if (m_rdata !== '0 || m_err !== 1'b0) begin errors++; $display("FAIL reset_resp: got rdata %h err %b want 0 0", m_rdata, m_err); end
    checks++; if ({s_we, s_addr, s_byteen, s_wdata} !== '0) begin errors++; $display("FAIL reset_s_fields: got %b %h %h %h want zeros", s_we, s_addr, s_byteen, s_wdata); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    next_cycle(); rst = 1'b0;
    sample();
    ptr = 0; exp_rdata = '0;
  endtask

  task automatic test_single_read();
    next_cycle();
    req = 3'b001; we_r[0] = 1'b0; addr_r[0] = 32'h100; be_r[0] = 4'hF; wdata_r[0] = '0;
    drive(); sample();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL read_c0_s_req: got %b want 0", s_req); end
    next_cycle(); sample();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h100 || s_we !== 1'b0 || grant_id !== 2'd0)
      begin errors++; $display("FAIL read_c1_issue: got req %b addr %h we %b gid %0d want 1 100 0 0", s_req, s_addr, s_we, grant_id); end
    next_cycle(); s_ack = 1'b1; s_rdata = 32'hDEADBEEF; s_err = 1'b0; sample();
    checks++; if (s_req !== 1'b1 || m_ack !== '0) begin errors++; $display("FAIL read_c2_busy: got req %b ack %b want 1 000", s_req, m_ack); end
    next_cycle(); s_ack = 1'b0; s_rdata = $urandom; sample();
    checks++; if (m_ack !== 3'b001 || m_rdata !== 32'hDEADBEEF || m_err !== 1'b0 || s_req !== 1'b0)
      begin errors++; $display("FAIL read_c3_ack: got ack %b rdata %h err %b req %b want 001 deadbeef 0 0", m_ack, m_rdata, m_err, s_req); end
    next_cycle(); req = '0; drive(); sample();
    checks++; if (m_ack !== '0 || m_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_c4_hold: got ack %b rdata %h want 000 deadbeef", m_ack, m_rdata); end
    ptr = 1; exp_rdata = 32'hDEADBEEF;
  endtask

  task automatic test_contention();
    int start;
    logic [XLEN-1:0] rd;
    start = ptr;
    req = 3'b111;
    for (int i = 0; i < NREQ; i++) begin
      we_r[i] = $urandom_range(0, 1); addr_r[i] = $urandom; be_r[i] = BW'($urandom); wdata_r[i] = $urandom;
    end
    s_ack = 1'b1; s_err = 1'b0;
    for (int n = 0; n < 6; n++) begin
      next_cycle(); drive(); sample();
      checks++; if (s_req !== 1'b0 || m_ack !== '0) begin errors++; $display("FAIL cont_idle[%0d]: got req %b ack %b want 0 000", n, s_req, m_ack); end
      next_cycle(); rd = $urandom; s_rdata = rd; sample();
      checks++; if (s_req !== 1'b1 || grant_id !== 2'((start + n) % NREQ) || s_addr !== addr_r[(start + n) % NREQ])
        begin errors++; $display("FAIL cont_grant[%0d]: got req %b gid %0d addr %h want 1 %0d %h", n, s_req, grant_id, s_addr, (start + n) % NREQ, addr_r[(start + n) % NREQ]); end
      next_cycle(); s_rdata = $urandom; sample();
      checks++; if (m_ack !== onehot((start + n) % NREQ) || m_rdata !== rd)
        begin errors++; $display("FAIL cont_ack[%0d]: got ack %b rdata %h want %b %h", n, m_ack, m_rdata, onehot((start + n) % NREQ), rd); end
    end
    ptr = (start + 6) % NREQ; exp_rdata = rd;
    next_cycle(); req = '0; s_ack = 1'b0; drive(); sample();
  endtask

  task automatic test_write();
    logic [XLEN-1:0] rd;
    next_cycle();
    req = 3'b100; we_r[2] = 1'b1; addr_r[2] = 32'h2004; be_r[2] = 4'b0011; wdata_r[2] = 32'h12345678;
    s_ack = 1'b0; drive(); sample();
    for (int k = 0; k < 4; k++) begin
      next_cycle(); s_ack = (k == 3); s_rdata = $urandom; rd = s_rdata; s_err = 1'b0; sample();
      checks++; if (s_req !== 1'b1 || s_we !== 1'b1 || s_addr !== 32'h2004 || s_byteen !== 4'b0011 || s_wdata !== 32'h12345678 || grant_id !== 2'd2)
        begin errors++; $display("FAIL write_fields[%0d]: got %b %b %h %b %h gid %0d want 1 1 2004 0011 12345678 2", k, s_req, s_we, s_addr, s_byteen, s_wdata, grant_id); end
    end
    next_cycle(); s_ack = 1'b0; sample();
    checks++; if (m_ack !== 3'b100 || m_err !== 1'b0 || m_rdata !== rd) begin errors++; $display("FAIL write_ack: got %b err %b rdata %h want 100 0 %h", m_ack, m_err, m_rdata, rd); end
    next_cycle(); req = '0; drive(); sample();
    ptr = 0; exp_rdata = rd;
  endtask

  task automatic test_error();
    logic [XLEN-1:0] rd;
    next_cycle();
    req = 3'b010; we_r[1] = 1'b0; addr_r[1] = 32'h40; be_r[1] = 4'hF; drive(); sample();
    // Requester drops m_req mid-transaction; the ack must still come.
    next_cycle(); req = '0; drive(); s_ack = 1'b0; sample();
    next_cycle(); s_ack = 1'b1; s_err = 1'b1; rd = $urandom; s_rdata = rd; sample();
    next_cycle(); s_ack = 1'b0; s_err = 1'b0; sample();
    checks++; if (m_ack !== 3'b010 || m_err !== 1'b1 || m_rdata !== rd) begin errors++; $display("FAIL error_ack: got %b err %b rdata %h want 010 1 %h", m_ack, m_err, m_rdata, rd); end
    next_cycle(); sample();
    ptr = 2; exp_rdata = rd;
  endtask

  task automatic test_reset_busy();
    logic [XLEN-1:0] rd;
    next_cycle(); req = 3'b110; addr_r[1] = 32'h1111_0000; addr_r[2] = 32'h2222_0000; drive(); sample();
    next_cycle(); sample();
    checks++; if (s_req !== 1'b1 || grant_id !== 2'(pick(req, ptr))) begin errors++; $display("FAIL rstb_grant: got req %b gid %0d want 1 %0d", s_req, grant_id, pick(req, ptr)); end
    next_cycle(); rst = 1'b1; sample();
    next_cycle(); rst = 1'b0; sample();
    checks++; if (s_req !== 1'b0 || m_ack !== '0 || grant_id !== 2'd0 || m_rdata !== '0)
      begin errors++; $display("FAIL rstb_cleared: got req %b ack %b gid %0d rdata %h want 0 000 0 0", s_req, m_ack, grant_id, m_rdata); end
    ptr = 0;
    next_cycle(); sample();
    checks++; if (s_req !== 1'b1 || m_ack !== '0 || grant_id !== 2'(pick(req, ptr)) || s_addr !== 32'h1111_0000)
      begin errors++; $display("FAIL rstb_regrant: got req %b ack %b gid %0d addr %h want 1 000 1 11110000", s_req, m_ack, grant_id, s_addr); end
    next_cycle(); s_ack = 1'b1; rd = $urandom; s_rdata = rd; sample();
    next_cycle(); s_ack = 1'b0; sample();
    checks++; if (m_ack !== 3'b010 || m_rdata !== rd) begin errors++; $display("FAIL rstb_ack: got %b rdata %h want 010 %h", m_ack, m_rdata, rd); end
    next_cycle(); req = '0; drive(); sample();
    ptr = 2; exp_rdata = rd;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      next_cycle(); req = 3'b001; addr_r[0] = 32'h300; we_r[0] = 1'b0; s_ack = 1'b0; drive(); sample();
      for (int c = 1; c <= 9; c++) begin
        next_cycle();
        s_ack = (pass == 1 && c == 9); s_rdata = (c == 9) ? 32'hCAFEF00D : $urandom; s_err = 1'b0;
        sample();
        checks++; if (s_req !== 1'b1 || m_ack !== '0) begin errors++; $display("FAIL tmo_wait[%0d/%0d]: got req %b ack %b want 1 000", pass, c, s_req, m_ack); end
      end
      next_cycle(); s_ack = 1'b0; sample();
      if (pass == 0) begin
        checks++; if (m_ack !== 3'b001 || m_err !== 1'b1 || m_rdata !== '0 || s_req !== 1'b0)
          begin errors++; $display("FAIL tmo_abort: got ack %b err %b rdata %h req %b want 001 1 0 0", m_ack, m_err, m_rdata, s_req); end
        exp_rdata = '0;
      end else begin
        checks++; if (m_ack !== 3'b001 || m_err !== 1'b0 || m_rdata !== 32'hCAFEF00D)
          begin errors++; $display("FAIL tmo_race: got ack %b err %b rdata %h want 001 0 cafef00d", m_ack, m_err, m_rdata); end
        exp_rdata = 32'hCAFEF00D;
      end
      next_cycle(); req = '0; drive(); sample();
      ptr = 1;
    end
  endtask
`endif

  task automatic test_random();
    int g, d;
    logic [XLEN-1:0] rd;
    logic            er;
    for (int n = 0; n < 200; n++) begin
      next_cycle();
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1; we_r[i] = $urandom_range(0, 1); addr_r[i] = $urandom;
          be_r[i] = BW'($urandom); wdata_r[i] = $urandom;
        end else if (req[i] && $urandom_range(0, 7) == 0) begin
          req[i] = 1'b0;
        end
      end
      s_ack = $urandom_range(0, 1); s_rdata = $urandom; s_err = $urandom_range(0, 1);
      drive(); sample();
      checks++; if (s_req !== 1'b0 || m_ack !== '0 || m_rdata !== exp_rdata)
        begin errors++; $display("FAIL rand_idle[%0d]: got req %b ack %b rdata %h want 0 000 %h", n, s_req, m_ack, m_rdata, exp_rdata); end
      g = pick(req, ptr);
      if (g >= 0) begin
        d  = $urandom_range(0, 3);
        rd = '0; er = 1'b0;
        for (int k = 0; k <= d; k++) begin
          next_cycle();
          s_ack = (k == d); s_rdata = $urandom; s_err = $urandom_range(0, 1);
          if (k == d) begin rd = s_rdata; er = s_err; end
          for (int i = 0; i < NREQ; i++) if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
          drive(); sample();
          checks++; if (s_req !== 1'b1 || m_ack !== '0 || grant_id !== 2'(g) || s_we !== we_r[g] ||
                        s_addr !== addr_r[g] || s_byteen !== be_r[g] || s_wdata !== wdata_r[g])
            begin errors++; $display("FAIL rand_busy[%0d]: got req %b gid %0d we %b addr %h be %h wd %h want 1 %0d %b %h %h %h",
                                     n, s_req, grant_id, s_we, s_addr, s_byteen, s_wdata, g, we_r[g], addr_r[g], be_r[g], wdata_r[g]); end
        end
        next_cycle(); s_ack = $urandom_range(0, 1); s_rdata = $urandom; sample();
        checks++; if (m_ack !== onehot(g) || m_rdata !== rd || m_err !== er || s_req !== 1'b0)
          begin errors++; $display("FAIL rand_ack[%0d]: got ack %b rdata %h err %b req %b want %b %h %b 0", n, m_ack, m_rdata, m_err, s_req, onehot(g), rd, er); end
        exp_rdata = rd;
        ptr       = (g + 1) % NREQ;
        req[g]    = 1'b0;
      end
    end
    next_cycle(); req = '0; s_ack = 1'b0; drive(); sample();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_read();
    test_contention();
    test_write();
    test_error();
    test_reset_busy();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
